ppu_reg_port: RTL and testbench

PPU_REG_PORT -- requirements
Module: ppu_reg_port

---
 rtl/ppu_reg_port.sv | 207 ++++++++++++++++++++
 tb/tb_ppu_reg_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_reg_port.sv
// CPU-facing PPU register block ($2000-$2007) with VRAM/OAM access sequencing.
// Build option: define PPU_OPEN_BUS_EN to return the last written byte on write-only registers.
module ppu_reg_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        ppu_reg_cs,
   input  logic        WE,
   input  logic [2:0]  ppu_reg_addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [13:0] vram_addr,
   output logic [7:0]  vram_data_out,
   input  logic [7:0]  vram_data_in,
   output logic        vram_WE,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data_out,
   input  logic [7:0]  oam_data_in,
   output logic        oam_WE,
   input  logic        vblank_set,
   input  logic        frame_clr,
   input  logic        spr0_hit,
   input  logic        spr_ovf,
   output logic [7:0]  ctrl,
   output logic [7:0]  mask,
   output logic [7:0]  scroll_x,
   output logic [7:0]  scroll_y,
   output logic        nmi
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_VWR  = 2'd1;
   localparam logic [1:0] S_VINC = 2'd2;
   localparam logic [1:0] S_OWR  = 2'd3;

   logic [1:0]  r_state;
   logic        r_cs_d;
   logic        r_pend;
   logic        r_pend_we;
   logic [2:0]  r_pend_idx;
   logic [7:0]  r_pend_data;
   logic [7:0]  r_data_out;
   logic [7:0]  r_ctrl;
   logic [7:0]  r_mask;
   logic [7:0]  r_scroll_x;
   logic [7:0]  r_scroll_y;
   logic [7:0]  r_oam_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_buf;
   logic [13:0] r_vram_addr;
   logic        r_vblank;
   logic        r_spr0;
   logic        r_ovf;
   logic        r_w;

   logic        w_ev;
   logic        w_do;
   logic        w_we;
   logic        w_status_rd;
   logic [2:0]  w_idx;
   logic [7:0]  w_din;
   logic [7:0]  w_obus;
   logic [13:0] w_inc;
   logic [13:0] w_vram_next;

   // An event is executed immediately when idle, otherwise it waits in the pending slot.
   assign w_ev        = ppu_reg_cs & ~r_cs_d;
   assign w_do        = (r_state == S_IDLE) & (w_ev | r_pend);
   assign w_we        = r_pend ? r_pend_we   : WE;
   assign w_idx       = r_pend ? r_pend_idx  : ppu_reg_addr;
   assign w_din       = r_pend ? r_pend_data : data_in;
   assign w_status_rd = w_do & ~w_we & (w_idx == 3'd2);
   assign w_inc       = r_ctrl[2] ? 14'd32 : 14'd1;
   assign w_vram_next = r_vram_addr + w_inc;

`ifdef PPU_OPEN_BUS_EN
   logic [7:0] r_obus;
   always_ff @(posedge clk) begin
      if (reset)
         r_obus <= 8'h00;
      else if (w_do && w_we)
         r_obus <= w_din;
   end
   assign w_obus = r_obus;
`else
   assign w_obus = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cs_d      <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_we   <= 1'b0;
         r_pend_idx  <= 3'd0;
         r_pend_data <= 8'h00;
      end else begin
         r_cs_d <= ppu_reg_cs;
         if (w_ev && ((r_state != S_IDLE) || r_pend)) begin
            r_pend      <= 1'b1;
            r_pend_we   <= WE;
            r_pend_idx  <= ppu_reg_addr;
            r_pend_data <= data_in;
         end else if (w_do) begin
            r_pend <= 1'b0;
         end
      end
   end

   // A vblank_set in the same cycle as a status read wins, so the flag is not lost.
   always_ff @(posedge clk) begin
      if (reset || frame_clr) begin
         r_vblank <= 1'b0;
         r_spr0   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (vblank_set)
            r_vblank <= 1'b1;
         else if (w_status_rd)
            r_vblank <= 1'b0;
         if (spr0_hit) r_spr0 <= 1'b1;
         if (spr_ovf)  r_ovf  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_data_out  <= 8'h00;
         r_ctrl      <= 8'h00;
         r_mask      <= 8'h00;
         r_scroll_x  <= 8'h00;
         r_scroll_y  <= 8'h00;
         r_oam_addr  <= 8'h00;
         r_wdata     <= 8'h00;
         r_buf       <= 8'h00;
         r_vram_addr <= 14'h0000;
         r_w         <= 1'b0;
      end else begin
         case (r_state)
            S_VWR: begin
               r_vram_addr <= w_vram_next;
               r_state     <= S_VINC;
            end
            S_VINC: r_state <= S_IDLE;
            S_OWR: begin
               r_oam_addr <= r_oam_addr + 8'd1;
               r_state    <= S_IDLE;
            end
            default: begin
               if (w_do && w_we) begin
                  case (w_idx)
                     3'd0: r_ctrl     <= w_din;
                     3'd1: r_mask     <= w_din;
                     3'd3: r_oam_addr <= w_din;
                     3'd4: begin
                        r_wdata <= w_din;
                        r_state <= S_OWR;
                     end
                     3'd5: begin
                        if (r_w) r_scroll_y <= w_din;
                        else     r_scroll_x <= w_din;
                        r_w <= ~r_w;
                     end
                     3'd6: begin
                        if (r_w) r_vram_addr[7:0]  <= w_din;
                        else     r_vram_addr[13:8] <= w_din[5:0];
                        r_w <= ~r_w;
                     end
                     3'd7: begin
                        r_wdata <= w_din;
                        r_state <= S_VWR;
                     end
                     default: ;
                  endcase
               end else if (w_do) begin
                  case (w_idx)
                     3'd2: begin
                        r_data_out <= {r_vblank, r_spr0, r_ovf, w_obus[4:0]};
                        r_w        <= 1'b0;
                     end
                     3'd4: r_data_out <= oam_data_in;
                     3'd7: begin
                        // Palette space bypasses the read buffer.
                        r_data_out  <= (r_vram_addr < 14'h3F00) ? r_buf : vram_data_in;
                        r_buf       <= vram_data_in;
                        r_vram_addr <= w_vram_next;
                     end
                     default: r_data_out <= w_obus;
                  endcase
               end
            end
         endcase
      end
   end

   assign data_out      = r_data_out;
   assign vram_addr     = r_vram_addr;
   assign vram_data_out = r_wdata;
   assign vram_WE       = (r_state == S_VWR);
   assign oam_addr      = r_oam_addr;
   assign oam_data_out  = r_wdata;
   assign oam_WE        = (r_state == S_OWR);
   assign ctrl          = r_ctrl;
   assign mask          = r_mask;
   assign scroll_x      = r_scroll_x;
   assign scroll_y      = r_scroll_y;
   assign nmi           = r_vblank & r_ctrl[7];

endmodule

// File: tb/tb_ppu_reg_port.sv
// Bench for ppu_reg_port: a register-level model of the PPU port checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ppu_reg_port;
   logic        clk = 1'b0;
   logic        reset;
   logic        ppu_reg_cs;
   logic        WE;
   logic [2:0]  ppu_reg_addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [13:0] vram_addr;
   logic [7:0]  vram_data_out;
   logic [7:0]  vram_data_in;
   logic        vram_WE;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data_out;
   logic [7:0]  oam_data_in;
   logic        oam_WE;
   logic        vblank_set;
   logic        frame_clr;
   logic        spr0_hit;
   logic        spr_ovf;
   logic [7:0]  ctrl;
   logic [7:0]  mask;
   logic [7:0]  scroll_x;
   logic [7:0]  scroll_y;
   logic        nmi;

   ppu_reg_port dut (
      .clk(clk), .reset(reset), .ppu_reg_cs(ppu_reg_cs), .WE(WE),
      .ppu_reg_addr(ppu_reg_addr), .data_in(data_in), .data_out(data_out),
      .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_in(vram_data_in),
      .vram_WE(vram_WE), .oam_addr(oam_addr), .oam_data_out(oam_data_out),
      .oam_data_in(oam_data_in), .oam_WE(oam_WE), .vblank_set(vblank_set),
      .frame_clr(frame_clr), .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .ctrl(ctrl),
      .mask(mask), .scroll_x(scroll_x), .scroll_y(scroll_y), .nmi(nmi)
   );

   always #5 clk = ~clk;

   // Environment memories driven by the DUT strobes.
   logic [7:0] vmem [16384];
   logic [7:0] omem [256];
   assign vram_data_in = vmem[vram_addr];
   assign oam_data_in  = omem[oam_addr];
   int oam_we_cnt = 0;
   always @(negedge clk) begin
      if (vram_WE) vmem[vram_addr] = vram_data_out;
      if (oam_WE) begin
         omem[oam_addr] = oam_data_out;
         oam_we_cnt++;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register-level model of what a CPU would observe.
   logic [7:0]  m_dout, m_ctrl, m_mask, m_sx, m_sy, m_oaddr, m_buf, m_obus;
   logic [7:0]  m_vram_wd, m_oam_wd;
   logic [13:0] m_vaddr;
   logic        m_vbl, m_s0, m_ov, m_w, m_vram_we, m_oam_we;
   logic [7:0]  m_vmem [16384];
   logic [7:0]  m_omem [256];

   task automatic model_reset();
      m_dout = 0; m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_oaddr = 0;
      m_buf = 0; m_obus = 0; m_vaddr = 0; m_vbl = 0; m_s0 = 0; m_ov = 0; m_w = 0;
      m_vram_we = 0; m_oam_we = 0; m_vram_wd = 0; m_oam_wd = 0;
   endtask

   function automatic logic [13:0] step_addr(input logic [13:0] a, input logic [7:0] c);
      int sum;
      sum = int'(a) + (c[2] ? 32 : 1);
      return 14'(sum % 16384);
   endfunction

   task automatic model_event(input logic we, input logic [2:0] idx, input logic [7:0] d);
      if (we) begin
`ifdef PPU_OPEN_BUS_EN
         m_obus = d;
`endif
         case (idx)
            3'd0: m_ctrl = d;
            3'd1: m_mask = d;
            3'd3: m_oaddr = d;
            3'd4: begin m_omem[m_oaddr] = d; m_oam_we = 1; m_oam_wd = d; end
            3'd5: begin if (!m_w) m_sx = d; else m_sy = d; m_w = !m_w; end
            3'd6: begin
               if (!m_w) m_vaddr = {d[5:0], m_vaddr[7:0]};
               else m_vaddr = {m_vaddr[13:8], d};
               m_w = !m_w;
            end
            3'd7: begin m_vmem[m_vaddr] = d; m_vram_we = 1; m_vram_wd = d; end
            default: ;
         endcase
      end else begin
         case (idx)
            3'd2: begin m_dout = {m_vbl, m_s0, m_ov, m_obus[4:0]}; m_vbl = 0; m_w = 0; end
            3'd4: m_dout = m_omem[m_oaddr];
            3'd7: begin
               m_dout  = (m_vaddr < 14'h3F00) ? m_buf : m_vmem[m_vaddr];
               m_buf   = m_vmem[m_vaddr];
               m_vaddr = step_addr(m_vaddr, m_ctrl);
            end
            default: m_dout = m_obus;
         endcase
      end
   endtask

   // Called at the end of each cycle after an event: strobes last one cycle, then the pointer moves.
   task automatic model_tick();
      if (m_vram_we) begin m_vram_we = 0; m_vaddr = step_addr(m_vaddr, m_ctrl); end
      if (m_oam_we) begin m_oam_we = 0; m_oaddr = 8'((int'(m_oaddr) + 1) % 256); end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("data_out", data_out, m_dout);
         check("vram_addr", vram_addr, m_vaddr);
         check("vram_WE", vram_WE, m_vram_we);
         if (m_vram_we) check("vram_data_out", vram_data_out, m_vram_wd);
         check("oam_addr", oam_addr, m_oaddr);
         check("oam_WE", oam_WE, m_oam_we);
         if (m_oam_we) check("oam_data_out", oam_data_out, m_oam_wd);
         check("ctrl", ctrl, m_ctrl);
         check("mask", mask, m_mask);
         check("scroll_x", scroll_x, m_sx);
         check("scroll_y", scroll_y, m_sy);
         check("nmi", nmi, m_vbl & m_ctrl[7]);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; model_tick(); end
   endtask

   task automatic access(input logic we, input logic [2:0] idx, input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      ppu_reg_cs = 1; WE = we; ppu_reg_addr = idx; data_in = d;
      @(posedge clk); #1;
      model_event(we, idx, d);
      wait_cycles(hold - 1);
      ppu_reg_cs = 0;
      wait_cycles(2);
   endtask

   task automatic pulse(input logic vs, input logic fc, input logic s0, input logic ov);
      @(posedge clk); #1;
      vblank_set = vs; frame_clr = fc; spr0_hit = s0; spr_ovf = ov;
      @(posedge clk); #1;
      if (fc) begin m_vbl = 0; m_s0 = 0; m_ov = 0; end
      else begin if (vs) m_vbl = 1; if (s0) m_s0 = 1; if (ov) m_ov = 1; end
      vblank_set = 0; frame_clr = 0; spr0_hit = 0; spr_ovf = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_ob;

   initial begin
      for (int i = 0; i < 16384; i++) begin vmem[i] = 0; m_vmem[i] = 0; end
      for (int i = 0; i < 256; i++) begin omem[i] = 0; m_omem[i] = 0; end
      vmem[14'h2000] = 8'h11; m_vmem[14'h2000] = 8'h11;
      vmem[14'h2020] = 8'h22; m_vmem[14'h2020] = 8'h22;
      vmem[14'h3F10] = 8'h2C; m_vmem[14'h3F10] = 8'h2C;
      vmem[14'h3FF0] = 8'h3A; m_vmem[14'h3FF0] = 8'h3A;
      reset = 1; ppu_reg_cs = 0; WE = 0; ppu_reg_addr = 0; data_in = 0;
      vblank_set = 0; frame_clr = 0; spr0_hit = 0; spr_ovf = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1; reset = 0; chk_en = 1;
      @(negedge clk);
      check("rst_data_out", data_out, 8'h00);
      check("rst_vram_addr", vram_addr, 14'h0);
      check("rst_ctrl", ctrl, 8'h00);
      check("rst_oam_addr", oam_addr, 8'h00);

      // VRAM write through address latch
      access(1, 6, 8'h21, 1);
      access(1, 6, 8'h08, 1);
      @(posedge clk); #1;
      ppu_reg_cs = 1; WE = 1; ppu_reg_addr = 7; data_in = 8'hAA;
      @(posedge clk); #1;
      model_event(1, 7, 8'hAA); ppu_reg_cs = 0;
      @(negedge clk);
      check("wr_strobe", vram_WE, 1);
      check("wr_addr", vram_addr, 14'h2108);
      check("wr_data", vram_data_out, 8'hAA);
      wait_cycles(1);
      @(negedge clk);
      check("wr_strobe_off", vram_WE, 0);
      check("wr_addr_inc", vram_addr, 14'h2109);
      wait_cycles(1);
      check("wr_mem", vmem[14'h2108], 8'hAA);

      // Buffered reads with +32 increment
      access(1, 0, 8'h04, 1);
      access(1, 6, 8'h20, 1);
      access(1, 6, 8'h00, 1);
      access(0, 7, 8'h00, 1);
      check("rd_buf_first", data_out, 8'h00);
      check("rd_addr_2020", vram_addr, 14'h2020);
      access(0, 7, 8'h00, 3);
      check("rd_buf_second", data_out, 8'h11);
      check("rd_addr_2040", vram_addr, 14'h2040);

      // Sprite flags and frame_clr priority
      pulse(0, 0, 1, 1);
      access(0, 2, 8'h00, 1);
      check("status_spr", data_out, 8'h60);
      pulse(1, 1, 1, 1);
      access(0, 2, 8'h00, 1);
      check("status_clr", data_out, 8'h00);

      // vblank / nmi
      access(1, 0, 8'h80, 1);
      pulse(1, 0, 0, 0);
      @(negedge clk);
      check("nmi_set", nmi, 1);
      access(0, 2, 8'h00, 2);
      check("status_vbl", data_out, 8'h80);
      check("nmi_clr", nmi, 0);
      access(0, 2, 8'h00, 1);
      check("status_vbl2", data_out, 8'h00);

      // vblank_set coinciding with a status read
      @(posedge clk); #1;
      ppu_reg_cs = 1; WE = 0; ppu_reg_addr = 2; vblank_set = 1;
      @(posedge clk); #1;
      model_event(0, 2, 8'h00); m_vbl = 1; vblank_set = 0; ppu_reg_cs = 0;
      wait_cycles(2);
      check("race_old", data_out, 8'h00);
      check("race_nmi", nmi, 1);
      access(0, 2, 8'h00, 1);
      check("race_after", data_out, 8'h80);

      // Status read resets the write toggle
      access(1, 6, 8'h3F, 1);
      access(0, 2, 8'h00, 1);
      access(1, 6, 8'h3F, 1);
      access(1, 6, 8'h10, 1);
      check("toggle_addr", vram_addr, 14'h3F10);

      // Palette read is direct
      access(0, 7, 8'h00, 1);
      check("pal_data", data_out, 8'h2C);
      check("pal_addr", vram_addr, 14'h3F11);

      // Address wrap, +1 and +32
      access(1, 6, 8'h3F, 1);
      access(1, 6, 8'hFF, 1);
      access(1, 7, 8'h77, 1);
      check("wrap1_addr", vram_addr, 14'h0000);
      check("wrap1_mem", vmem[14'h3FFF], 8'h77);
      access(1, 0, 8'h84, 1);
      access(1, 6, 8'h3F, 1);
      access(1, 6, 8'hF0, 1);
      access(0, 7, 8'h00, 1);
      check("wrap32_data", data_out, 8'h3A);
      check("wrap32_addr", vram_addr, 14'h0010);

      // OAM write with long chip-select, then OAM read
      access(1, 3, 8'hFF, 1);
      oam_we_cnt = 0;
      access(1, 4, 8'h5A, 4);
      check("oam_we_count", oam_we_cnt, 1);
      check("oam_mem", omem[8'hFF], 8'h5A);
      check("oam_wrap", oam_addr, 8'h00);
      access(1, 3, 8'hFF, 1);
      access(0, 4, 8'h00, 1);
      check("oam_read", data_out, 8'h5A);
      check("oam_noinc", oam_addr, 8'hFF);

      // Scroll and mask
      access(1, 5, 8'h12, 1);
      access(1, 5, 8'h34, 1);
      access(1, 1, 8'h1E, 1);
      check("scroll_x_lit", scroll_x, 8'h12);
      check("scroll_y_lit", scroll_y, 8'h34);
      check("mask_lit", mask, 8'h1E);

      // Write-only register reads
`ifdef PPU_OPEN_BUS_EN
      exp_ob = 8'h1E;
`else
      exp_ob = 8'h00;
`endif
      access(0, 0, 8'h00, 1);
      check("openbus_0", data_out, exp_ob);
      access(0, 6, 8'h00, 1);
      check("openbus_6", data_out, exp_ob);

      // Event arriving during VINC is deferred and uses the captured data
      @(posedge clk); #1;
      ppu_reg_cs = 1; WE = 1; ppu_reg_addr = 7; data_in = 8'h55;
      @(posedge clk); #1;
      model_event(1, 7, 8'h55); ppu_reg_cs = 0;
      @(posedge clk); #1;
      model_tick(); ppu_reg_cs = 1; WE = 1; ppu_reg_addr = 0; data_in = 8'h01;
      @(posedge clk); #1;
      model_tick(); ppu_reg_cs = 0; ppu_reg_addr = 5; data_in = 8'hFF;
      @(posedge clk); #1;
      model_event(1, 0, 8'h01);
      wait_cycles(2);
      check("defer_ctrl", ctrl, 8'h01);
      check("defer_addr", vram_addr, 14'h0030);
      check("defer_mem", vmem[14'h0010], 8'h55);

      // Reset during VWR
      @(posedge clk); #1;
      ppu_reg_cs = 1; WE = 1; ppu_reg_addr = 7; data_in = 8'h99;
      @(posedge clk); #1;
      model_event(1, 7, 8'h99); ppu_reg_cs = 0; reset = 1;
      @(negedge clk);
      check("abort_pre", vram_WE, 1);
      @(posedge clk); #1;
      model_reset(); reset = 0;
      @(negedge clk);
      check("abort_we", vram_WE, 0);
      check("abort_addr", vram_addr, 14'h0);
      check("abort_ctrl", ctrl, 8'h00);
      check("abort_mask", mask, 8'h00);
      check("abort_scroll", {scroll_x, scroll_y}, 16'h0000);
      check("abort_dout", data_out, 8'h00);
      wait_cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
